// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the serial magnitude comparator.
//   state_t  : FSM state encoding (IDLE / COMPARE / DONE)
//   SLICE_W  : width of the slice examined per clock by comparator_2bit
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/comparator_2bit.sv
// -----------------------------------------------------------------------------
// comparator_2bit
// Purely combinational unsigned magnitude comparator for one 2-bit slice.
// Ports:
//   a, b   : 2-bit slice operands
//   eq     : a == b
//   gt     : a >  b
//   lt     : a <  b
// -----------------------------------------------------------------------------
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    // Exactly one of the three flags is high for any pair of slices.
    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
// Sequential WIDTH-bit unsigned magnitude comparator. Operands are latched on
// an accepted start, then compared one 2-bit slice per clock from the MSB
// slice down, stopping at the first slice that differs.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset (aborts any comparison)
//   start  : request pulse, accepted in IDLE and in DONE
//   a, b   : operands, sampled only in the accept cycle
//   busy   : high while slices are being compared
//   done   : one-cycle pulse when eq/gt/lt/steps are fresh
//   eq/gt/lt : registered result of the last completed comparison
//   steps  : number of slices examined by the last comparison (1..SLICES)
// -----------------------------------------------------------------------------
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int SLICES = WIDTH / 2,
    localparam int CW     = $clog2(SLICES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    steps
);

    // Slice index needs at least one bit even when there is a single slice.
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic [CW-1:0]      steps_q, steps_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_eq;
    logic               slice_gt;
    logic               slice_lt;

    // Select the slice currently pointed at by idx from the latched operands.
    always_comb begin
        slice_a = ra_q[SLICE_W*idx_q +: SLICE_W];
        slice_b = rb_q[SLICE_W*idx_q +: SLICE_W];
    end

    comparator_2bit u_cmp (
        .a  (slice_a),
        .b  (slice_b),
        .eq (slice_eq),
        .gt (slice_gt),
        .lt (slice_lt)
    );

    // Next-state and datapath logic. Results are only written on the edge
    // that moves COMPARE into DONE, so they hold between completions.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        steps_d = steps_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    idx_d   = IW'(SLICES - 1);
                    cnt_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_COMPARE: begin
                cnt_d = cnt_q + 1'b1;
                if (!slice_eq) begin
                    // First differing slice decides the whole comparison.
                    eq_d    = 1'b0;
                    gt_d    = slice_gt;
                    lt_d    = slice_lt;
                    steps_d = cnt_q + 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    steps_d = CW'(SLICES);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also clears any half-done result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            steps_q <= steps_d;
        end
    end

    // busy/done decode directly from the registered state.
    always_comb begin
        busy  = (state_q == S_COMPARE);
        done  = (state_q == S_DONE);
        eq    = eq_q;
        gt    = gt_q;
        lt    = lt_q;
        steps = steps_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_magnitude_comparator
// Self-checking bench for serial_magnitude_comparator (WIDTH=8): directed
// scenarios followed by random operand pairs, all checked against a
// reference model built from plain unsigned arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

    localparam int WIDTH  = 8;
    localparam int SLICES = WIDTH / 2;
    localparam int CW     = $clog2(SLICES + 1);
    localparam int BUDGET = 20;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CW-1:0]    steps;

    int checks = 0;
    int errors = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt),
        .steps (steps)
    );

    // Single comparison point: counts, asserts, and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: relations come from plain unsigned compare; the number of
    // slices examined follows from the highest differing bit position.
    function automatic void refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     output logic e, output logic g, output logic l,
                                     output int st);
        logic [WIDTH-1:0] diff;
        bit               found;
        diff  = x ^ y;
        found = 1'b0;
        e     = (x == y);
        g     = (x > y);
        l     = (x < y);
        st    = SLICES;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && diff[i]) begin
                found = 1'b1;
                st    = SLICES - i / 2;
            end
        end
    endfunction

    // Present operands with start high; the next rising edge accepts them.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
    endtask

    // Watch cycles after the accept edge until done. Optionally pulse start
    // (with a changed) in cycle pulse_at, or chain a new request in the DONE cycle.
    task automatic waitDone(input int pulse_at, input bit chain,
                            input logic [WIDTH-1:0] nx, input logic [WIDTH-1:0] ny,
                            output int lat, output int busy_cycles,
                            output logic busy_at_done, output bit seen);
        seen         = 1'b0;
        lat          = 0;
        busy_cycles  = 0;
        busy_at_done = 1'b0;
        for (int n = 1; n <= BUDGET && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen         = 1'b1;
                lat          = n;
                busy_at_done = busy;
            end else if (busy) begin
                busy_cycles++;
            end
            if (seen && chain) begin
                a     = nx;
                b     = ny;
                start = 1'b1;
            end else if (n == pulse_at) begin
                a     = '1;
                start = 1'b1;
            end else begin
                start = 1'b0;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
        end
    endtask

    // Compare everything observed for one transaction against the model.
    task automatic checkResult(input string tag, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input int lat,
                               input int busy_cycles, input logic busy_at_done,
                               input bit seen);
        logic e, g, l;
        int   st;
        refModel(x, y, e, g, l, st);
        checkOutput({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            checkOutput({tag, "_eq"}, 32'(eq), 32'(e));
            checkOutput({tag, "_gt"}, 32'(gt), 32'(g));
            checkOutput({tag, "_lt"}, 32'(lt), 32'(l));
            checkOutput({tag, "_steps"}, 32'(steps), 32'(st));
            checkOutput({tag, "_latency"}, 32'(lat), 32'(st + 1));
            checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(st));
            checkOutput({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
        end
    endtask

    // Full non-chained transaction plus a check that done lasts one cycle
    // and the result holds afterwards.
    task automatic runCompare(input string tag, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input int pulse_at);
        int   lat, bc;
        logic bad;
        bit   seen;
        logic e, g, l;
        int   st;
        applyStimulus(x, y);
        waitDone(pulse_at, 1'b0, '0, '0, lat, bc, bad, seen);
        checkResult(tag, x, y, lat, bc, bad, seen);
        refModel(x, y, e, g, l, st);
        @(negedge clk);
        checkOutput({tag, "_done_single"}, 32'(done), 0);
        checkOutput({tag, "_hold_gt"}, 32'(gt), 32'(g));
        checkOutput({tag, "_hold_steps"}, 32'(steps), 32'(st));
    endtask

    initial begin
        int               lat, bc, done_count;
        logic             bad;
        bit               seen;
        logic [WIDTH-1:0] x, y;
        int               mode;

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_eq", 32'(eq), 0);
        checkOutput("rst_gt", 32'(gt), 0);
        checkOutput("rst_lt", 32'(lt), 0);
        checkOutput("rst_steps", 32'(steps), 0);

        // Early exit on the top slice, full scans ending unequal and equal.
        runCompare("gt_top", 8'hA5, 8'h35, 0);
        runCompare("lt_low", 8'h3C, 8'h3D, 0);
        runCompare("eq_ff", 8'hFF, 8'hFF, 0);

        // A start pulse while busy must be ignored.
        runCompare("ignore_start", 8'h40, 8'h41, 1);

        // Reset in the second COMPARE cycle aborts without a done pulse.
        applyStimulus(8'h12, 8'h13);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_eq", 32'(eq), 0);
        checkOutput("abort_gt", 32'(gt), 0);
        checkOutput("abort_lt", 32'(lt), 0);
        checkOutput("abort_steps", 32'(steps), 0);
        done_count = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("abort_no_done", 32'(done_count), 0);
        runCompare("after_abort", 8'h02, 8'h01, 0);

        // Back-to-back: new request accepted in the DONE cycle.
        applyStimulus(8'hC0, 8'h00);
        waitDone(0, 1'b1, 8'h00, 8'hC0, lat, bc, bad, seen);
        checkResult("b2b_first", 8'hC0, 8'h00, lat, bc, bad, seen);
        waitDone(0, 1'b0, '0, '0, lat, bc, bad, seen);
        checkResult("b2b_second", 8'h00, 8'hC0, lat, bc, bad, seen);

        // Random pairs, biased towards equal or nearly-equal operands.
        for (int k = 0; k < 24; k++) begin
            x    = WIDTH'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0)      y = WIDTH'($urandom);
            else if (mode == 1) y = x;
            else                y = x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            runCompare("random", x, y, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Sequential N-bit magnitude comparator built around the existing combinational comparator_2bit.
- Latches two WIDTH-bit operands on a start request.
- Compares them one 2-bit slice per clock, MSB slice first, stopping at the first unequal slice.
- Reports eq/gt/lt, plus the number of slices examined, with a one-cycle done pulse.
- Sits downstream of operand producers (counters, register file) and replaces wide combinational compare logic where area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2.
SLICES, WIDTH/2, derived localparam; number of 2-bit slices.
CW, $clog2(SLICES+1), derived localparam; width of the steps output.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only when the block is not busy.
a  input  WIDTH  operand A; sampled in the start-accept cycle.
b  input  WIDTH  operand B; sampled in the start-accept cycle.
busy  output  1  high while in COMPARE.
done  output  1  one-cycle pulse when the result is valid.
eq  output  1  registered result: a == b.
gt  output  1  registered result: a > b.
lt  output  1  registered result: a < b.
steps  output  CW  number of slices examined in the last comparison (1..SLICES).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, eq, gt, lt = 0; steps = 0; idx and operand registers = 0.
- Reset takes priority over everything. Asserting it mid-COMPARE aborts the operation: no done, and results clear to 0.
- FSM has three states: IDLE, COMPARE, DONE.
- IDLE:
  - start=1: latch a→ra and b→rb, set idx=SLICES-1, cnt=0, go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE (busy=1):
  - comparator_2bit is driven with ra[2*idx+1:2*idx] and rb[2*idx+1:2*idx]; cnt increments each cycle.
  - Slice gt or lt: register gt/lt (eq=0), steps=cnt+1, go to DONE.
  - Slice eq and idx==0: register eq=1 (gt=lt=0), steps=SLICES, go to DONE.
  - Slice eq and idx>0: idx decrements, stay in COMPARE.
- DONE (done=1 for exactly this cycle):
  - start=1: accept immediately (latch, go to COMPARE); back-to-back operation allowed.
  - Otherwise go to IDLE.
- start is ignored while in COMPARE.
- Operand inputs are don't-care after the accept cycle; only ra/rb are used.
- Latency: with the start accepted at edge E, done is high during the cycle after edge E+k, where k = slices examined (1..SLICES). Minimum 2 cycles; maximum SLICES+1 cycles (5 for WIDTH=8).
- eq, gt, lt and steps update on the same edge that raises done, and hold until the next completion or reset.
- After the first completion exactly one of eq/gt/lt is high. Before the first completion, all are 0.
- Unsigned comparison only.

Decomposition:
- Shared package cmp_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_COMPARE=2'd1, S_DONE=2'd2;
  - the SLICE_W=2 constant.
- One sub-module instance: the existing comparator_2bit (ports a, b, eq, gt, lt), purely combinational on the selected slice.
- Slice mux, index counter and FSM live in the top module.

Test Plan (WIDTH=8):
1. Reset, then a=8'hA5, b=8'h35, 1-cycle start → busy for 1 cycle; done 2 cycles after the accept edge; gt=1, eq=lt=0, steps=1.
2. a=8'h3C, b=8'h3D → busy for 4 cycles; done at the 5th cycle; lt=1, steps=4.
3. a=b=8'hFF → eq=1, gt=lt=0, steps=4, done after 5 cycles.
4. Start a=8'h40, b=8'h41, then change a to 8'hFF and pulse start again while busy → second start ignored; result lt=1, steps=4, only one done pulse.
5. Start a=8'h12, b=8'h13; assert rst for 1 cycle during the 2nd COMPARE cycle → no done; all outputs 0; a following start of a=8'h02, b=8'h01 completes with gt=1, steps=4.
6. Back-to-back: a=8'hC0, b=8'h00 (gt, steps=1), then start held high in the DONE cycle with a=8'h00, b=8'hC0 → second done exactly 2 cycles after the first; lt=1, steps=1.
